// File: rtl/range_value_counter_if.sv
// Range-load and value streams for range_value_counter, each a valid/ready handshake.
interface range_value_counter_if #(
  parameter int DATA_WIDTH = 49
);
  logic                  range_valid;
  logic                  range_ready;
  logic [DATA_WIDTH-1:0] range_lo;
  logic [DATA_WIDTH-1:0] range_hi;
  logic                  range_last;

  logic                  value_valid;
  logic                  value_ready;
  logic [DATA_WIDTH-1:0] value;
  logic                  value_last;

  modport master (
    output range_valid, range_lo, range_hi, range_last,
    output value_valid, value, value_last,
    input  range_ready, value_ready
  );

  modport slave (
    input  range_valid, range_lo, range_hi, range_last,
    input  value_valid, value, value_last,
    output range_ready, value_ready
  );
endinterface

// File: rtl/range_value_counter.sv
// Loads a list of inclusive [lo,hi] ranges, then counts streamed values that fall in any range,
// scanning RANGE_PARALLELISM ranges per cycle with early exit on the first match.
module range_value_counter #(
  parameter int DATA_WIDTH        = 49,
  parameter int MAX_RANGES        = 256,
  parameter int RANGE_PARALLELISM = 1,
  parameter int COUNTER_WIDTH     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  range_value_counter_if.slave     bus,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic                     done,
  output logic                     count_sat,
  output logic                     range_overflow
);

  localparam int P      = RANGE_PARALLELISM;
  localparam int GROUPS = (MAX_RANGES + P - 1) / P;
  localparam int N_W    = $clog2(MAX_RANGES + 1);
  localparam int G_W    = $clog2(GROUPS + 1);
  localparam int IDX_W  = $clog2((GROUPS + 1) * P + 1);
  localparam int AW     = (MAX_RANGES > 1) ? $clog2(MAX_RANGES) : 1;

  localparam logic [1:0] LOAD_RANGES = 2'd0;
  localparam logic [1:0] WAIT_VALUE  = 2'd1;
  localparam logic [1:0] SCAN        = 2'd2;
  localparam logic [1:0] DONE        = 2'd3;

  logic [1:0]            state;
  logic [N_W-1:0]        n;
  logic [G_W-1:0]        g;
  logic [DATA_WIDTH-1:0] value_q;
  logic                  last_q;

  logic [DATA_WIDTH-1:0] lo_mem [MAX_RANGES];
  logic [DATA_WIDTH-1:0] hi_mem [MAX_RANGES];

  logic                  any_match;
  logic                  last_group;
  logic                  scan_end;
  logic [IDX_W-1:0]      lane_idx;
  logic [AW-1:0]         lane_addr;

  logic range_fire;
  logic value_fire;
  logic room;

  // Ready depends on state only, never on valid.
  assign bus.range_ready = (state == LOAD_RANGES);
  assign bus.value_ready = (state == WAIT_VALUE);
  assign done            = (state == DONE);

  assign range_fire = bus.range_valid && (state == LOAD_RANGES);
  assign value_fire = bus.value_valid && (state == WAIT_VALUE);
  assign room       = (n != N_W'(MAX_RANGES));

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    any_match = 1'b0;
    lane_idx  = '0;
    lane_addr = '0;
    for (int i = 0; i < P; i++) begin
      lane_idx = IDX_W'(g) * IDX_W'(P) + IDX_W'(i);
      if (lane_idx < IDX_W'(n)) begin
        lane_addr = lane_idx[AW-1:0];
        // A range stored with lo > hi can never satisfy both bounds.
        if ((hi_mem[lane_addr] >= value_q) && (lo_mem[lane_addr] <= value_q)) begin
          any_match = 1'b1;
        end
      end
    end
  end

  // An empty table still yields one scan cycle because (0+1)*P >= 0.
  assign last_group = ((IDX_W'(g) + IDX_W'(1)) * IDX_W'(P)) >= IDX_W'(n);
  assign scan_end   = any_match || last_group;

  // NOTE: range storage has no reset; entries at or beyond n are never compared, so stale
  // contents are harmless and the arrays can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!clear && range_fire && room) begin
      lo_mem[n[AW-1:0]] <= bus.range_lo;
      hi_mem[n[AW-1:0]] <= bus.range_hi;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= LOAD_RANGES;
      n              <= '0;
      g              <= '0;
      value_q        <= '0;
      last_q         <= 1'b0;
      count          <= '0;
      count_sat      <= 1'b0;
      range_overflow <= 1'b0;
    end else if (clear) begin
      state          <= LOAD_RANGES;
      n              <= '0;
      g              <= '0;
      last_q         <= 1'b0;
      count          <= '0;
      count_sat      <= 1'b0;
      range_overflow <= 1'b0;
    end else begin
      case (state)
        LOAD_RANGES: begin
          if (range_fire) begin
            if (room) n <= n + N_W'(1);
            else      range_overflow <= 1'b1;
            if (bus.range_last) state <= WAIT_VALUE;
          end
        end
        WAIT_VALUE: begin
          if (value_fire) begin
            value_q <= bus.value;
            last_q  <= bus.value_last;
            g       <= '0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (scan_end) begin
            if (any_match) begin
              if (count == '1) count_sat <= 1'b1;
              else             count     <= count + COUNTER_WIDTH'(1);
            end
            state <= last_q ? DONE : WAIT_VALUE;
          end else begin
            g <= g + G_W'(1);
          end
        end
        default: ;  // DONE holds until clear or rst
      endcase
    end
  end

endmodule

// File: tb/tb_range_value_counter.sv
// Scoreboard bench for range_value_counter: a small reference model predicts match and scan
// length per value, compared when the DUT finishes each scan.
module tb_range_value_counter;

  localparam int DW = 49;
  localparam logic [DW-1:0] VMAX = '1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic clear_r = 1'b0;
  logic sel = 1'b0;

  logic          rv = 1'b0, rlast = 1'b0, vv = 1'b0, vlast = 1'b0;
  logic [DW-1:0] rlo = '0, rhi = '0, vval = '0;

  range_value_counter_if #(.DATA_WIDTH(DW)) bus_a ();
  range_value_counter_if #(.DATA_WIDTH(DW)) bus_b ();

  assign bus_a.range_valid = rv & ~sel;
  assign bus_b.range_valid = rv & sel;
  assign bus_a.value_valid = vv & ~sel;
  assign bus_b.value_valid = vv & sel;
  assign bus_a.range_lo = rlo;  assign bus_b.range_lo = rlo;
  assign bus_a.range_hi = rhi;  assign bus_b.range_hi = rhi;
  assign bus_a.range_last = rlast;  assign bus_b.range_last = rlast;
  assign bus_a.value = vval;  assign bus_b.value = vval;
  assign bus_a.value_last = vlast;  assign bus_b.value_last = vlast;

  logic [1:0] count_a;
  logic [9:0] count_b;
  logic       done_a, done_b, sat_a, sat_b, ovf_a, ovf_b;
  logic       clear_a, clear_b;
  assign clear_a = clear_r & ~sel;
  assign clear_b = clear_r & sel;

  range_value_counter #(.DATA_WIDTH(DW), .MAX_RANGES(4), .RANGE_PARALLELISM(1), .COUNTER_WIDTH(2)) dut_a (
    .clk(clk), .rst(rst), .clear(clear_a), .bus(bus_a.slave),
    .count(count_a), .done(done_a), .count_sat(sat_a), .range_overflow(ovf_a)
  );

  range_value_counter #(.DATA_WIDTH(DW), .MAX_RANGES(8), .RANGE_PARALLELISM(4), .COUNTER_WIDTH(10)) dut_b (
    .clk(clk), .rst(rst), .clear(clear_b), .bus(bus_b.slave),
    .count(count_b), .done(done_b), .count_sat(sat_b), .range_overflow(ovf_b)
  );

  logic       rr, vr, dn, sat, ovf;
  logic [9:0] cnt;
  assign rr  = sel ? bus_b.range_ready : bus_a.range_ready;
  assign vr  = sel ? bus_b.value_ready : bus_a.value_ready;
  assign dn  = sel ? done_b : done_a;
  assign sat = sel ? sat_b : sat_a;
  assign ovf = sel ? ovf_b : ovf_a;
  assign cnt = sel ? count_b : {8'd0, count_a};

  typedef struct {
    bit match;
    int cycles;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] m_lo[$];
  logic [DW-1:0] m_hi[$];
  int            m_count;
  bit            m_sat, m_ovf;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int max_r();  return sel ? 8 : 4;     endfunction
  function automatic int par();    return sel ? 4 : 1;     endfunction
  function automatic int cmax();   return sel ? 1023 : 3;  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_lo.delete();
    m_hi.delete();
    sb.delete();
    m_count = 0;
    m_sat   = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_clear();
    clear_r = 1'b1;
    tick();
    clear_r = 1'b0;
    model_reset();
    check("clear_count", cnt, 0);
    check("clear_done", dn, 0);
    check("clear_sat", sat, 0);
    check("clear_ovf", ovf, 0);
    check("clear_range_ready", rr, 1);
  endtask

  task automatic wait_ready(input bit for_value);
    int t = 0;
    while (!(for_value ? vr : rr) && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) check(for_value ? "value_ready_timeout" : "range_ready_timeout",
                        for_value ? vr : rr, 1);
  endtask

  task automatic load_range(input logic [DW-1:0] lo, input logic [DW-1:0] hi, input bit last);
    wait_ready(1'b0);
    rlo = lo; rhi = hi; rlast = last; rv = 1'b1;
    tick();
    rv = 1'b0;
    if (m_lo.size() < max_r()) begin
      m_lo.push_back(lo);
      m_hi.push_back(hi);
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic send_value(input logic [DW-1:0] v, input bit last);
    exp_t e;
    int   first = -1;
    int   n = m_lo.size();
    int   k = 0;
    for (int i = 0; i < n; i++)
      if (first < 0 && m_lo[i] <= v && v <= m_hi[i]) first = i;
    e.match  = (first >= 0);
    e.cycles = e.match ? (first / par() + 1) : ((n == 0) ? 1 : (n + par() - 1) / par());
    if (e.match) begin
      if (m_count == cmax()) m_sat = 1'b1;
      else                   m_count++;
    end
    sb.push_back(e);

    wait_ready(1'b1);
    vval = v; vlast = last; vv = 1'b1;
    tick();
    vv = 1'b0;
    do begin
      tick();
      k++;
    end while (!vr && !dn && k < 500);

    e = sb.pop_front();
    check("scan_cycles", k, e.cycles);
    check("count", cnt, m_count);
    check("count_sat", sat, m_sat);
    check("range_overflow", ovf, m_ovf);
    check("done", dn, last);
  endtask

  task automatic load_basic();
    load_range(3, 5, 1'b0);
    load_range(10, 14, 1'b0);
    load_range(16, 20, 1'b0);
    load_range(12, 18, 1'b1);
  endtask

  task automatic run_basic();
    send_value(1, 1'b0);
    send_value(5, 1'b0);
    send_value(8, 1'b0);
    send_value(11, 1'b0);
    send_value(17, 1'b0);
    send_value(32, 1'b1);
    check("basic_final_count", cnt, 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected earlier", $time);
    $fatal(1);
  end

  initial begin
    sel = 1'b0;
    do_reset();
    check("reset_range_ready", rr, 1);
    check("reset_value_ready", vr, 0);
    check("reset_count", cnt, 0);
    check("reset_done", dn, 0);
    check("reset_sat", sat, 0);
    check("reset_ovf", ovf, 0);

    // One lane per cycle: scan length follows the first matching index.
    load_basic();
    check("loaded_value_ready", vr, 1);
    run_basic();

    // Four lanes: every value resolves in a single scan cycle.
    sel = 1'b1;
    do_reset();
    load_basic();
    run_basic();

    // Full-width range plus an inverted range.
    sel = 1'b0;
    do_clear();
    load_range('0, VMAX, 1'b0);
    load_range(7, 6, 1'b1);
    send_value('0, 1'b0);
    send_value(VMAX, 1'b0);
    send_value(7, 1'b1);
    do_clear();
    load_range(7, 6, 1'b1);
    send_value(7, 1'b1);
    check("inverted_only_count", cnt, 0);

    // Two-bit counter saturates.
    do_clear();
    load_range(0, 100, 1'b1);
    for (int i = 0; i < 5; i++) send_value(50, i == 4);
    check("sat_final_count", cnt, 3);
    check("sat_flag", sat, 1);

    // Six ranges into four slots: the last two are dropped.
    do_clear();
    for (int i = 0; i < 6; i++) load_range(DW'(i), DW'(i), i == 5);
    check("overflow_flag", ovf, 1);
    send_value(4, 1'b0);
    send_value(5, 1'b1);
    do_clear();

    // Reset mid-scan discards partial progress.
    load_basic();
    send_value(1, 1'b0);
    send_value(5, 1'b0);
    wait_ready(1'b1);
    vval = 8; vlast = 1'b0; vv = 1'b1;
    tick();
    vv = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("midscan_rst_count", cnt, 0);
    check("midscan_rst_value_ready", vr, 0);
    check("midscan_rst_range_ready", rr, 1);
    tick();
    rst = 1'b0;
    model_reset();
    check("post_rst_range_ready", rr, 1);
    load_basic();
    run_basic();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
